// File: rtl/evbox_pkg.sv
// evbox_in shared types: event record and default widths.
// Optional timestamp build: EVBOX_IN_TIMESTAMP_EN.
package evbox_pkg;

  localparam int EVBOX_N   = 4;
  localparam int EVBOX_TSW = 32;

  typedef struct packed {
    logic [EVBOX_N-1:0]   data;
    logic [EVBOX_N-1:0]   mask;
    logic [EVBOX_TSW-1:0] tstamp;
  } evbox_event_t;

endpackage

// File: rtl/evbox_in_fifo.sv
// Event record FIFO; push into a full FIFO is taken when
// a pop happens on the same cycle.
module evbox_in_fifo
  import evbox_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  evbox_event_t i_din,
  input  logic         i_pop,
  output evbox_event_t o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wp;
  logic [AW:0]  r_rp;
  evbox_event_t r_mem [DEPTH];
  logic         w_push;
  logic         w_pop;

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_dout  = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/evbox_in.sv
// Event input box: sync, debounce, edge detect, timestamped FIFO.
// Timestamp counter present only with EVBOX_IN_TIMESTAMP_EN.
module evbox_in
  import evbox_pkg::*;
#(
  parameter int N        = EVBOX_N,
  parameter int DEBOUNCE = 16,
  parameter int DEPTH    = 8,
  parameter int TSW      = EVBOX_TSW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   io_port,
  input  logic [N-1:0]   rise_en,
  input  logic [N-1:0]   fall_en,
  input  logic           clear_overflow,
  output logic           ev_valid,
  input  logic           ev_ready,
  output logic [N-1:0]   ev_data,
  output logic [N-1:0]   ev_mask,
  output logic [TSW-1:0] ev_time,
  output logic           overflow,
  output logic [N-1:0]   data_in
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [N-1:0]   r_s1;
  logic [N-1:0]   r_s2;
  logic [N-1:0]   r_stb;
  logic [CW-1:0]  r_cnt [N];
  logic [N-1:0]   w_upd;
  logic [N-1:0]   w_stb_nxt;
  logic [N-1:0]   w_qual;
  logic [TSW-1:0] w_ts;

  evbox_event_t r_rec;
  logic         r_rec_v;
  logic         r_ovf;
  evbox_event_t w_dout;
  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  logic         w_drop;

  always_comb begin
    w_upd = '0;
    for (int i = 0; i < N; i++) begin
      w_upd[i] = (r_s2[i] != r_stb[i]) &&
                 (r_cnt[i] == CW'(DEBOUNCE));
    end
  end

  assign w_stb_nxt = r_stb ^ w_upd;
  assign w_qual = (w_upd & w_stb_nxt & rise_en) |
                  (w_upd & ~w_stb_nxt & fall_en);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_stb <= '0;
    end else begin
      r_s1  <= io_port;
      r_s2  <= r_s1;
      r_stb <= w_stb_nxt;
    end
  end

  // Counter runs only while synced value disagrees with stable level
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset || (r_s2[i] == r_stb[i]) || w_upd[i])
        r_cnt[i] <= '0;
      else
        r_cnt[i] <= r_cnt[i] + CW'(1);
    end
  end

`ifdef EVBOX_IN_TIMESTAMP_EN
  logic [TSW-1:0] r_ts;

  always_ff @(posedge clk) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + 1'b1;
  end

  assign w_ts = r_ts;
`else
  assign w_ts = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rec_v <= 1'b0;
      r_rec   <= '0;
    end else begin
      r_rec_v <= |w_qual;
      r_rec   <= '{data: w_stb_nxt, mask: w_qual, tstamp: w_ts};
    end
  end

  assign w_pop  = ~w_empty & ev_ready;
  assign w_drop = r_rec_v & w_full & ~w_pop;

  evbox_in_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_rec_v),
    .i_din   (r_rec),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset)               r_ovf <= 1'b0;
    else if (w_drop)         r_ovf <= 1'b1;
    else if (clear_overflow) r_ovf <= 1'b0;
  end

  assign ev_valid = ~w_empty;
  assign ev_data  = w_empty ? '0 : w_dout.data;
  assign ev_mask  = w_empty ? '0 : w_dout.mask;
  assign ev_time  = w_empty ? '0 : w_dout.tstamp;
  assign overflow = r_ovf;
  assign data_in  = r_stb;

endmodule

// File: doc/evbox_in.md
# evbox_in

Input-side companion of the LC/GC event IO box output port. Samples N asynchronous event lines from the instrument and synchronizes and debounces them. Detects enabled rising/falling edges and queues timestamped event records in a small FIFO, which the host-side register/DMA logic drains over a valid/ready stream. Also exposes the debounced line levels for direct status readback.

## Interface
- `N`, 4: number of event input lines.
- `DEBOUNCE`, 16: consecutive stable cycles required to accept a new level; legal range 1..65535.
- `DEPTH`, 8: event FIFO depth; power of two, ≥ 2.
- `TSW`, 32: timestamp counter width.

- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `io_port` in N: raw asynchronous event lines.
- `rise_en` in N: per-line rising-edge event enable.
- `fall_en` in N: per-line falling-edge event enable.
- `clear_overflow` in 1: single-cycle pulse that clears `overflow`.
- `ev_valid` out 1: head FIFO record is available.
- `ev_ready` in 1: consumer accepts the head record.
- `ev_data` out N: debounced levels of all lines at event time.
- `ev_mask` out N: lines whose enabled edge caused this record.
- `ev_time` out TSW: timestamp of the event.
- `overflow` out 1: sticky flag; an event was dropped.
- `data_in` out N: current debounced levels.

## Operation
- Each line uses a 2-FF synchronizer (reset 0), then a per-line debounce counter.
- The counter clears whenever the synchronized value equals the stable level. Otherwise it increments.
- When the counter reaches `DEBOUNCE`, the stable level takes the synchronized value and the counter clears.
- Edge = stable level change on that cycle. Qualifying edge = 0→1 with `rise_en`, or 1→0 with `fall_en`.
- On any cycle with ≥1 qualifying edge, exactly one record is formed:
  - `ev_mask` = qualifying lines.
  - `ev_data` = new stable levels.
  - `ev_time` = timestamp counter value on that cycle.
- Disabled edges update `data_in` but produce no record.
- Timestamp counter: TSW-bit, free-running from 0 after reset, wraps modulo 2^TSW with no flag.
- FIFO write is attempted on the cycle after the edge. When the FIFO is full:
  - If a pop (`ev_valid & ev_ready`) occurs that same cycle, the write is accepted.
  - Otherwise the record is dropped and `overflow` is set.
- `overflow` stays set until `clear_overflow`. If a set and a clear coincide, set wins.
- Stream rules:
  - `ev_valid` high ⇔ FIFO non-empty.
  - Outputs hold stable while `ev_valid & !ev_ready`.
  - A pop occurs only on `ev_valid & ev_ready`.
- Reset mid-operation: FIFO emptied, counters, stable levels and timestamp cleared, `overflow` cleared. Enables are sampled live and not reset.
- Line high out of reset: after debounce it is reported as a rising edge if `rise_en` is set.

## Timing
- Reset values: `ev_valid`=0, `ev_data`=0, `ev_mask`=0, `ev_time`=0, `overflow`=0, `data_in`=0.
- Raw change first sampled at edge k: synchronized at k+2, stable level updates at k+2+DEBOUNCE, `ev_valid` high after edge k+3+DEBOUNCE (empty FIFO).
- Recorded `ev_time` = timestamp value at k+2+DEBOUNCE.
- Glitches shorter than `DEBOUNCE` synchronized cycles are ignored entirely.
- Sustained throughput: one record per cycle in, one pop per cycle out.

## Configuration
- `EVBOX_IN_TIMESTAMP_EN` defined: timestamp counter present and `ev_time` carries the captured value.
- Not defined: counter and FIFO timestamp storage removed, `ev_time` tied to 0; all other behaviour unchanged.

## Structure
- Package `evbox_pkg`:
  - `evbox_event_t` struct {data, mask, time}.
  - Default constants `EVBOX_N`, `EVBOX_TSW`.
- Sub-module `evbox_in_fifo`: synchronous FIFO of `evbox_event_t`, DEPTH entries, full/empty, simultaneous push/pop when full allowed.
- Synchronizer and debounce stay inline in `evbox_in`.

## Test plan
- Reset, then line 0 goes 0→1 with `rise_en`=4'b0001, DEBOUNCE=4 → `ev_valid` after 7 cycles; `ev_mask`=0001, `ev_data`=0001, `ev_time`=6.
- 3-cycle high glitch on line 2, DEBOUNCE=4 → no record, `data_in` stays 0.
- Lines 1 and 3 rise together; `rise_en`=1111 → single record, `ev_mask`=1010.
- `ev_ready`=0, 9 qualifying events with DEPTH=8 → 8 records held, `overflow`=1. Then `clear_overflow` → 0, and records drain in order with increasing `ev_time`.
- FIFO full, pop and new event on the same cycle → no overflow, occupancy stays 8.
- `fall_en`=0, line drops 1→0 → `data_in` updates, no record. Reset asserted with 3 queued records → `ev_valid`=0 on the next cycle.
